// File: rtl/muldiv_unit_if.sv
// Operand/result bus between the register-file side and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] result;

  modport master (output start, op, opa, opb, input busy, done, dbz, result);
  modport slave  (input start, op, opa, opb, output busy, done, dbz, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply (shift-add) / unsigned restoring divide, one iteration per clock.
// Optional MULDIV_EARLY_OUT_EN: MUL stops once the multiplier is exhausted, divide-by-zero skips RUN.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, rem_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg, done_reg, dbz_reg;
  logic [WIDTH-1:0] result_reg;

  logic [WIDTH-1:0] a_next, b_next, acc_next, rem_next, result_next;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic             q_bit, dbz_next, last_iter;

  // a_reg doubles as multiplicand (shifted left) and dividend/quotient shift register.
  always_comb begin
    rem_shift   = {rem_reg, a_reg[WIDTH-1]};
    rem_diff    = rem_shift - {1'b0, b_reg};
    q_bit       = ~rem_diff[WIDTH];
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    rem_next    = rem_reg;
    if (op_reg == OP_MUL) begin
      acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
      a_next   = a_reg << 1;
      b_next   = b_reg >> 1;
    end else begin
      rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      a_next   = {a_reg[WIDTH-2:0], q_bit};
    end
    case (op_reg)
      OP_MUL:  result_next = acc_next;
      OP_DIVU: result_next = a_next;
      OP_REMU: result_next = rem_next;
      default: result_next = '0;
    endcase
    dbz_next  = ((op_reg == OP_DIVU) || (op_reg == OP_REMU)) && (b_reg == '0);
`ifdef MULDIV_EARLY_OUT_EN
    last_iter = (count_reg == CW'(WIDTH-1)) || ((op_reg == OP_MUL) && (b_next == '0));
`else
    last_iter = (count_reg == CW'(WIDTH-1));
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg    <= bus.op;
            a_reg     <= bus.opa;
            b_reg     <= bus.opb;
            acc_reg   <= '0;
            rem_reg   <= '0;
            count_reg <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            if (((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (bus.opb == '0)) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              dbz_reg    <= 1'b1;
              result_reg <= (bus.op == OP_DIVU) ? '1 : bus.opa;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
`else
            state_reg <= RUN;
            busy_reg  <= 1'b1;
`endif
          end
        end
        RUN: begin
          a_reg     <= a_next;
          b_reg     <= b_next;
          acc_reg   <= acc_next;
          rem_reg   <= rem_next;
          count_reg <= count_reg + 1'b1;
          if (last_iter) begin
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            result_reg <= result_next;
            dbz_reg    <= dbz_next;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.dbz    = dbz_reg;
  assign bus.result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_muldiv_unit;
  localparam logic [1:0] MUL = 2'b00, DIVU = 2'b01, REMU = 2'b10;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int L_7X6 = 3, L_FX2 = 2, L_2X3 = 2, L_DZ = 0, L_T5 = 12;
`else
  localparam int L_7X6 = 16, L_FX2 = 16, L_2X3 = 16, L_DZ = 16, L_T5 = 16;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [15:0] res;
    logic        dbz;
    int          lat;
    int          cyc;
  } exp_t;

  logic Clk, Reset;
  muldiv_unit_if #(.WIDTH(16)) bus ();
  muldiv_unit #(.WIDTH(16)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  exp_t sb[$];
  int   cyc = 0;
  logic rst_d = 1'b0;
  logic idle_chk = 1'b0;
  logic timeout_flag = 1'b0;
  logic timeout_seen = 1'b0;
  int   busy_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_d <= Reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_dbz"},    32'(bus.dbz),    32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
  endtask

  // Monitor: the only process that touches the counters.
  always @(negedge Clk) begin
    exp_t e;
    if (rst_d) begin
      check_quiet("reset");
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (idle_chk) check_quiet("idle");
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no completion", bus.result);
        end else begin
          e = sb.pop_front();
          $display("txn op=%0d result=0x%04h dbz=%0b busy_cycles=%0d latency=%0d", e.op, bus.result,
                   bus.dbz, busy_cnt, cyc - e.cyc - 1);
          check("result",      32'(bus.result),        32'(e.res));
          check("dbz",         32'(bus.dbz),           32'(e.dbz));
          check("busy_cycles", 32'(busy_cnt),          32'(e.lat));
          check("latency",     32'(cyc - e.cyc - 1),   32'(e.lat));
        end
        busy_cnt = 0;
      end
    end
    if (timeout_flag && !timeout_seen) begin
      timeout_seen = 1'b1;
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got %0d outstanding ops, expected 0", sb.size());
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic dbz, input int lat);
    exp_t e;
    @(negedge Clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    e.op = op; e.res = res; e.dbz = dbz; e.lat = lat; e.cyc = cyc;
    sb.push_back(e);
    @(negedge Clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) timeout_flag = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic dbz, input int lat);
    start_op(op, a, b, res, dbz, lat);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = 16'h0000;
    bus.opb   = 16'h0000;

    // Reset then quiet idle.
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    idle_chk = 1'b1;
    repeat (5) @(negedge Clk);
    idle_chk = 1'b0;

    // Multiply.
    run_op(MUL, 16'h0007, 16'h0006, 16'h002A, 1'b0, L_7X6);
    run_op(MUL, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b0, L_FX2);

    // Divide / remainder.
    run_op(DIVU, 16'd100, 16'd7, 16'd14, 1'b0, 16);
    run_op(REMU, 16'd100, 16'd7, 16'd2,  1'b0, 16);

    // Divide by zero, then a MUL clears dbz.
    run_op(DIVU, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, L_DZ);
    run_op(REMU, 16'h1234, 16'h0000, 16'h1234, 1'b1, L_DZ);
    run_op(MUL,  16'd2,    16'd3,    16'd6,    1'b0, L_2X3);

    // Reserved op.
    run_op(2'b11, 16'h5555, 16'h0003, 16'h0000, 1'b0, 16);

    // Second start mid-run is ignored; operands change after latching.
    start_op(MUL, 16'h0123, 16'h0810, 16'h2A30, 1'b0, L_T5);
    bus.op  = DIVU;
    bus.opa = 16'hFFFF;
    bus.opb = 16'hFFFF;
    repeat (4) @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    wait_done();
    repeat (20) @(negedge Clk);

    // Reset mid-divide aborts; a fresh divide then works.
    start_op(DIVU, 16'd100, 16'd7, 16'd14, 1'b0, 16);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    run_op(DIVU, 16'd50, 16'd5, 16'd10, 1'b0, 16);

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
